dmem_arbiter: RTL

Byte-serial arbiter and sequencer for the shared 32-byte, 8-bit-wide data memory. Two word requesters, the processor load/store port (port 0) and the loader/DMA port (port 1), request 32-bit reads or writes. The block grants one requester at a time with round-robin fairness and breaks each word access into four big-endian byte beats on the single memory port. It sits between the datapath's ALU-address/store-data path and the `datmem` array.

---
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two 32-bit word requesters sharing one 8-bit data memory.
// Each word access becomes four big-endian byte beats; reads need one extra cycle to collect the last byte.
module dmem_arbiter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // Handshake: a port raises req and holds we/addr/wdata stable until gnt shows
  // it owns the bus; the fields are latched then, and done pulses for one cycle
  // when the word is finished. req is only looked at while the arbiter is idle.

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_q, last_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [23:0]         shift_q, shift_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      base_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      shift_q <= 24'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      base_q  <= base_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    base_d  = base_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    win     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // On a tie the port that did not win last time goes first.
          win     = (req == 2'b11) ? ~last_q : req[1];
          last_d  = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          base_d  = win ? addr1 : addr0;
          we_d    = win ? we[1] : we[0];
          wdata_d = win ? wdata1 : wdata0;
          cnt_d   = 2'd0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 2'd1;
        // mem_rdata now carries the byte addressed by the previous beat.
        if (!we_q) begin
          case (cnt_q)
            2'd1:    shift_d[23:16] = mem_rdata;
            2'd2:    shift_d[15:8]  = mem_rdata;
            2'd3:    shift_d[7:0]   = mem_rdata;
            default: ;
          endcase
        end
        if (cnt_q == 2'd3) begin
          state_d = we_q ? S_RESP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        rdata_d = {shift_q, mem_rdata};
        state_d = S_RESP;
      end
      S_RESP: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  logic [7:0] beat_byte;

  always_comb begin
    beat_byte = 8'd0;
    case (cnt_q)
      2'd0: beat_byte = wdata_q[31:24];
      2'd1: beat_byte = wdata_q[23:16];
      2'd2: beat_byte = wdata_q[15:8];
      2'd3: beat_byte = wdata_q[7:0];
      default: ;
    endcase
  end

  // Memory-side outputs decode only registered state, never req.
  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? (base_q + ADDR_W'(cnt_q)) : '0;
  assign mem_wdata = mem_en ? beat_byte : 8'd0;

  assign gnt       = gnt_q;
  assign done      = (state_q == S_RESP) ? gnt_q : 2'b00;
  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule
